// File: rtl/err_accum_seq.sv
// err_accum_seq
//   Snapshots NUM_CH IR readings when IR_vld strobes, then walks the channels
//   one per clock building a signed, saturating steering error. Even channels
//   (right sensors) add, odd channels (left sensors) subtract. With
//   WEIGHT_MODE=0, pair k carries a weight of 2^k; with WEIGHT_MODE=1, every
//   channel has a weight of 1. The finished error is presented on err together
//   with a one-cycle err_vld pulse for the PID controller downstream.
//
// Ports
//   clk      in   clock
//   rst_n    in   asynchronous, active-low reset
//   IR_vld   in   one-cycle strobe, new readings present on ir_data
//   ir_data  in   NUM_CH*DW packed readings, channel i at [i*DW +: DW]
//   sel      out  channel currently being accumulated (0 when idle)
//   busy     out  high while a run is in progress
//   err      out  signed error, held between completed runs
//   err_vld  out  one-cycle pulse after err has been updated
module err_accum_seq #(
  parameter int NUM_CH      = 8,
  parameter int DW          = 12,
  parameter int ACC_W       = 16,
  parameter int WEIGHT_MODE = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      IR_vld,
  input  logic [NUM_CH*DW-1:0]      ir_data,
  output logic [$clog2(NUM_CH)-1:0] sel,
  output logic                      busy,
  output logic [ACC_W-1:0]          err,
  output logic                      err_vld
);

  localparam int SEL_W = $clog2(NUM_CH);
  // Headroom for the largest shifted term plus a signed accumulator, so the
  // unclamped sum can never wrap before it is compared against the limits.
  localparam int EXT_W = ACC_W + DW + NUM_CH / 2 + 1;

  localparam logic signed [EXT_W-1:0] ACC_MAX =
    {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] ACC_MIN =
    {{(EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  state_t                    state_q, state_d;
  logic [SEL_W-1:0]          cnt_q, cnt_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [ACC_W-1:0]   err_q, err_d;
  logic                      err_vld_q, err_vld_d;
  logic [NUM_CH*DW-1:0]      snap_q;

  logic [DW-1:0]             raw;
  logic [SEL_W-1:0]          shamt;
  logic signed [EXT_W-1:0]   term;
  logic signed [EXT_W-1:0]   acc_ext;
  logic signed [EXT_W-1:0]   sum;
  logic signed [ACC_W-1:0]   acc_sat;
  logic                      last_ch;

  // Weighted term for the current channel and the clamped running sum.
  // Clamping happens every step, so a later term of opposite sign can pull
  // the accumulator back off a rail.
  always_comb begin
    raw     = snap_q[32'(cnt_q)*DW +: DW];
    shamt   = (WEIGHT_MODE != 0) ? '0 : (cnt_q >> 1);
    term    = {{(EXT_W-DW){1'b0}}, raw} << shamt;
    acc_ext = EXT_W'(acc_q);
    sum     = cnt_q[0] ? (acc_ext - term) : (acc_ext + term);
    if (sum > ACC_MAX) begin
      acc_sat = ACC_MAX[ACC_W-1:0];
    end else if (sum < ACC_MIN) begin
      acc_sat = ACC_MIN[ACC_W-1:0];
    end else begin
      acc_sat = sum[ACC_W-1:0];
    end
    last_ch = (cnt_q == SEL_W'(NUM_CH-1));
  end

  // Next-state logic. A strobe always wins, so a strobe arriving mid-run or
  // on the final channel edge restarts the run and suppresses that completion.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    err_d     = err_q;
    err_vld_d = 1'b0;
    if (IR_vld) begin
      state_d = ACCUM;
      cnt_d   = '0;
      acc_d   = '0;
    end else if (state_q == ACCUM) begin
      acc_d = acc_sat;
      if (last_ch) begin
        err_d     = acc_sat;
        err_vld_d = 1'b1;
        state_d   = IDLE;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      err_q     <= '0;
      err_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      err_q     <= err_d;
      err_vld_q <= err_vld_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q <= '0;
    end else if (IR_vld) begin
      snap_q <= ir_data;
    end
  end

  assign busy    = (state_q == ACCUM);
  assign sel     = busy ? cnt_q : '0;
  assign err     = err_q;
  assign err_vld = err_vld_q;

endmodule

// File: tb/tb_err_accum_seq.sv
// tb_err_accum_seq
//   Directed-vector bench for err_accum_seq. The main instance uses the
//   default parameters (8 channels, binary pair weights). A second instance
//   uses 4 channels with unit weights. Inputs are driven on the falling edge,
//   and outputs are sampled on the falling edge before any new drive.
module tb_err_accum_seq;

  logic        clk;
  logic        rst_n;
  logic        ir_vld;
  logic [95:0] ir_data;
  logic [2:0]  sel;
  logic        busy;
  logic [15:0] err;
  logic        err_vld;

  logic        ir_vld_w;
  logic [47:0] ir_data_w;
  logic [1:0]  sel_w;
  logic        busy_w;
  logic [15:0] err_w;
  logic        err_vld_w;

  int total;
  int bad;

  err_accum_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .IR_vld  (ir_vld),
    .ir_data (ir_data),
    .sel     (sel),
    .busy    (busy),
    .err     (err),
    .err_vld (err_vld)
  );

  err_accum_seq #(
    .NUM_CH      (4),
    .DW          (12),
    .ACC_W       (16),
    .WEIGHT_MODE (1)
  ) dut_w (
    .clk     (clk),
    .rst_n   (rst_n),
    .IR_vld  (ir_vld_w),
    .ir_data (ir_data_w),
    .sel     (sel_w),
    .busy    (busy_w),
    .err     (err_w),
    .err_vld (err_vld_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Packs one reading for every right (even) channel and another for every
  // left (odd) channel.
  function automatic logic [95:0] mk(input logic [11:0] r, input logic [11:0] l);
    logic [95:0] d;
    d = '0;
    for (int i = 0; i < 8; i++) d[i*12 +: 12] = (i % 2 == 0) ? r : l;
    return d;
  endfunction

  // Called on a falling edge. Strobes for one cycle and returns on the
  // falling edge just after the strobe was sampled.
  task automatic pulse_ir(input logic [95:0] d);
    ir_vld  = 1'b1;
    ir_data = d;
    @(negedge clk);
    ir_vld  = 1'b0;
  endtask

  // Counts falling edges until err_vld is seen, capped at 30.
  task automatic wait_done(output int edges);
    edges = 0;
    while (err_vld !== 1'b1 && edges < 30) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic test_reset;
    total++; if (sel !== 3'd0) begin bad++; $display("[TB] FAIL reset_sel got=%0d want=0", sel); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    total++; if (err !== 16'h0000) begin bad++; $display("[TB] FAIL reset_err got=%h want=0000", err); end
    total++; if (err_vld !== 1'b0) begin bad++; $display("[TB] FAIL reset_err_vld got=%b want=0", err_vld); end
    total++; if (err_w !== 16'h0000 || err_vld_w !== 1'b0 || busy_w !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_w got err=%h vld=%b busy=%b want 0000/0/0", err_w, err_vld_w, busy_w);
    end
  endtask

  task automatic test_right_weighted;
    pulse_ir(mk(12'h100, 12'h000));
    for (int k = 0; k < 8; k++) begin
      total++; if (sel !== 3'(k) || busy !== 1'b1) begin
        bad++; $display("[TB] FAIL walk_sel got sel=%0d busy=%b want sel=%0d busy=1", sel, busy, k);
      end
      @(negedge clk);
    end
    total++; if (err_vld !== 1'b1) begin bad++; $display("[TB] FAIL walk_latency got err_vld=%b want=1", err_vld); end
    total++; if (err !== 16'h0F00) begin bad++; $display("[TB] FAIL walk_err got=%h want=0f00", err); end
    total++; if (busy !== 1'b0 || sel !== 3'd0) begin
      bad++; $display("[TB] FAIL walk_idle got busy=%b sel=%0d want 0/0", busy, sel);
    end
    @(negedge clk);
    total++; if (err_vld !== 1'b0 || err !== 16'h0F00) begin
      bad++; $display("[TB] FAIL walk_hold got vld=%b err=%h want 0/0f00", err_vld, err);
    end
  endtask

  task automatic test_cancel;
    int busy_cnt;
    int vld_cnt;
    busy_cnt = 0;
    vld_cnt  = 0;
    pulse_ir(mk(12'h7FF, 12'h7FF));
    for (int i = 0; i < 12; i++) begin
      if (busy === 1'b1) busy_cnt++;
      if (err_vld === 1'b1) vld_cnt++;
      @(negedge clk);
    end
    total++; if (busy_cnt != 8) begin bad++; $display("[TB] FAIL cancel_busy got=%0d want=8", busy_cnt); end
    total++; if (vld_cnt != 1) begin bad++; $display("[TB] FAIL cancel_vld got=%0d want=1", vld_cnt); end
    total++; if (err !== 16'h0000) begin bad++; $display("[TB] FAIL cancel_err got=%h want=0000", err); end
  endtask

  task automatic test_saturation;
    int e;
    pulse_ir(mk(12'h000, 12'hFFF));
    wait_done(e);
    total++; if (e != 8) begin bad++; $display("[TB] FAIL sat_neg_latency got=%0d want=8", e); end
    total++; if (err !== 16'h8000) begin bad++; $display("[TB] FAIL sat_neg_err got=%h want=8000", err); end
    @(negedge clk);
    pulse_ir(mk(12'hFFF, 12'h000));
    wait_done(e);
    total++; if (err !== 16'h7FFF) begin bad++; $display("[TB] FAIL sat_pos_err got=%h want=7fff", err); end
    @(negedge clk);
  endtask

  task automatic test_restart;
    int e;
    pulse_ir(mk(12'h000, 12'h0FF));
    @(negedge clk);
    @(negedge clk);
    pulse_ir(mk(12'h100, 12'h080));
    wait_done(e);
    total++; if (e != 8) begin bad++; $display("[TB] FAIL restart_latency got=%0d want=8", e); end
    total++; if (err !== 16'd1920) begin bad++; $display("[TB] FAIL restart_err got=%h want=%h", err, 16'd1920); end
    @(negedge clk);
    total++; if (err_vld !== 1'b0) begin bad++; $display("[TB] FAIL restart_single got=%b want=0", err_vld); end
  endtask

  task automatic test_last_edge_restart;
    int e;
    pulse_ir(mk(12'h010, 12'h000));
    repeat (7) @(negedge clk);
    total++; if (sel !== 3'd7) begin bad++; $display("[TB] FAIL last_sel got=%0d want=7", sel); end
    pulse_ir(mk(12'h020, 12'h000));
    total++; if (err_vld !== 1'b0 || err !== 16'd1920) begin
      bad++; $display("[TB] FAIL last_restart got vld=%b err=%h want 0/%h", err_vld, err, 16'd1920);
    end
    total++; if (busy !== 1'b1 || sel !== 3'd0) begin
      bad++; $display("[TB] FAIL last_busy got busy=%b sel=%0d want 1/0", busy, sel);
    end
    wait_done(e);
    total++; if (e != 8 || err !== 16'd480) begin
      bad++; $display("[TB] FAIL last_result got edges=%0d err=%h want 8/%h", e, err, 16'd480);
    end
  endtask

  task automatic test_back_to_back;
    int e;
    total++; if (err_vld !== 1'b1) begin bad++; $display("[TB] FAIL b2b_pulse got=%b want=1", err_vld); end
    pulse_ir(mk(12'h000, 12'h001));
    total++; if (err_vld !== 1'b0 || busy !== 1'b1 || err !== 16'd480) begin
      bad++; $display("[TB] FAIL b2b_start got vld=%b busy=%b err=%h want 0/1/%h", err_vld, busy, err, 16'd480);
    end
    wait_done(e);
    total++; if (e != 8 || err !== 16'hFFF1) begin
      bad++; $display("[TB] FAIL b2b_result got edges=%0d err=%h want 8/fff1", e, err);
    end
    @(negedge clk);
  endtask

  task automatic test_unit_weight;
    int e;
    ir_vld_w  = 1'b1;
    ir_data_w = {12'd1, 12'd7, 12'd3, 12'd10};
    @(negedge clk);
    ir_vld_w = 1'b0;
    total++; if (busy_w !== 1'b1 || sel_w !== 2'd0) begin
      bad++; $display("[TB] FAIL unit_start got busy=%b sel=%0d want 1/0", busy_w, sel_w);
    end
    e = 0;
    while (err_vld_w !== 1'b1 && e < 30) begin
      @(negedge clk);
      e++;
    end
    total++; if (e != 4) begin bad++; $display("[TB] FAIL unit_latency got=%0d want=4", e); end
    total++; if (err_w !== 16'd13) begin bad++; $display("[TB] FAIL unit_err got=%0d want=13", err_w); end
    @(negedge clk);
    total++; if (err_vld_w !== 1'b0 || busy_w !== 1'b0) begin
      bad++; $display("[TB] FAIL unit_idle got vld=%b busy=%b want 0/0", err_vld_w, busy_w);
    end
  endtask

  task automatic test_async_reset;
    int vld_cnt;
    pulse_ir(mk(12'h100, 12'h000));
    repeat (4) @(negedge clk);
    total++; if (sel !== 3'd4) begin bad++; $display("[TB] FAIL arst_sel_before got=%0d want=4", sel); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (sel !== 3'd0 || busy !== 1'b0 || err !== 16'h0000 || err_vld !== 1'b0) begin
      bad++; $display("[TB] FAIL arst_clear got sel=%0d busy=%b err=%h vld=%b want 0/0/0000/0", sel, busy, err, err_vld);
    end
    @(negedge clk);
    rst_n = 1'b1;
    vld_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (err_vld === 1'b1 || busy === 1'b1) vld_cnt++;
    end
    total++; if (vld_cnt != 0 || err !== 16'h0000) begin
      bad++; $display("[TB] FAIL arst_quiet got activity=%0d err=%h want 0/0000", vld_cnt, err);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    ir_vld    = 1'b0;
    ir_data   = '0;
    ir_vld_w  = 1'b0;
    ir_data_w = '0;
    repeat (2) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_right_weighted;
    test_cancel;
    test_saturation;
    test_restart;
    test_last_edge_restart;
    test_back_to_back;
    test_unit_weight;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
